// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   DIGIT_W : width of one compared digit (2 bits per cycle)
//   state_t : FSM encoding, IDLE=0 / COMPARE=1 / DONE=2
package serial_mag_comparator_pkg;

   localparam int DIGIT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/serial_mag_comparator_cmp2.sv
// comparator_2bit: purely combinational magnitude compare of one 2-bit digit.
//   a, b    : digit operands (unsigned)
//   a_gt_b  : a > b
//   a_lt_b  : a < b
//   a_eq_b  : a == b
module comparator_2bit
   import serial_mag_comparator_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   output logic               a_gt_b,
   output logic               a_lt_b,
   output logic               a_eq_b
);

   assign a_gt_b = (a > b);
   assign a_lt_b = (a < b);
   assign a_eq_b = (a == b);

endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: compares two WIDTH-bit unsigned operands one 2-bit
// digit per cycle, MSB digit first, stopping at the first unequal digit.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (a, b captured on accept edge)
//   out_valid/out_ready : result handshake
//   a_gt_b/a_lt_b/a_eq_b: registered one-hot result, zero while out_valid=0
// WIDTH must be even and >= 2.
module serial_mag_comparator
   import serial_mag_comparator_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             a_gt_b,
   output logic             a_lt_b,
   output logic             a_eq_b
);

   localparam int DIGITS = WIDTH / DIGIT_W;
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sb;
   logic [CW-1:0]    cnt;
   logic             gt_q, lt_q, eq_q;
   logic             dig_gt, dig_lt, dig_eq;

   // The slice always looks at the top digit; shifting brings the next one up.
   comparator_2bit u_cmp (
      .a      (sa[WIDTH-1 -: DIGIT_W]),
      .b      (sb[WIDTH-1 -: DIGIT_W]),
      .a_gt_b (dig_gt),
      .a_lt_b (dig_lt),
      .a_eq_b (dig_eq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (in_valid) state_nxt = ST_COMPARE;
         ST_COMPARE: if (!dig_eq || cnt == '0) state_nxt = ST_DONE;
         ST_DONE:    if (out_ready) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa   <= '0;
         sb   <= '0;
         cnt  <= '0;
         gt_q <= 1'b0;
         lt_q <= 1'b0;
         eq_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sa  <= a;
                  sb  <= b;
                  cnt <= CW'(DIGITS - 1);
               end
            end
            ST_COMPARE: begin
               if (dig_gt)           gt_q <= 1'b1;
               else if (dig_lt)      lt_q <= 1'b1;
               else if (cnt == '0)   eq_q <= 1'b1;
               else begin
                  sa  <= sa << DIGIT_W;
                  sb  <= sb << DIGIT_W;
                  cnt <= cnt - CW'(1);
               end
            end
            ST_DONE: begin
               // Flags drop together with out_valid so they are never stale.
               if (out_ready) begin
                  gt_q <= 1'b0;
                  lt_q <= 1'b0;
                  eq_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign a_gt_b    = gt_q;
   assign a_lt_b    = lt_q;
   assign a_eq_b    = eq_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       in_ready8, out_valid8, gt8, lt8, eq8;

   logic       in_valid2 = 1'b0, out_ready2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       in_ready2, out_valid2, gt2, lt2, eq2;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_mag_comparator #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
      .a_gt_b(gt8), .a_lt_b(lt8), .a_eq_b(eq8));

   serial_mag_comparator #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
      .a_gt_b(gt2), .a_lt_b(lt2), .a_eq_b(eq2));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      int         hold;
      logic [2:0] flags;   // {gt, lt, eq}
      int         lat;
   } vec_t;

   // {in_ready, out_valid, gt, lt, eq}
   function automatic logic [4:0] st(input bit w2);
      return w2 ? {in_ready2, out_valid2, gt2, lt2, eq2}
                : {in_ready8, out_valid8, gt8, lt8, eq8};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: 1-based index of the first differing digit from the MSB.
   function automatic int ref_lat(input logic [7:0] av, input logic [7:0] bv, input int w);
      for (int i = 0; i < w / 2; i++)
         if (av[w-1-2*i -: 2] != bv[w-1-2*i -: 2]) return i + 1;
      return w / 2;
   endfunction

   function automatic logic [2:0] ref_flags(input logic [7:0] av, input logic [7:0] bv);
      return {av > bv, av < bv, av == bv};
   endfunction

   task automatic drive_in(input bit w2, input logic v, input logic [7:0] av, input logic [7:0] bv);
      if (w2) begin in_valid2 = v; a2 = av[1:0]; b2 = bv[1:0]; end
      else    begin in_valid8 = v; a8 = av;      b8 = bv;      end
   endtask

   task automatic drive_rdy(input bit w2, input logic r);
      if (w2) out_ready2 = r;
      else    out_ready8 = r;
   endtask

   // Waits (bounded) for out_valid, checking in_ready stays low meanwhile.
   task automatic wait_ov(input bit w2, input string tag, output int lat);
      logic [4:0] s;
      lat = 0;
      s = st(w2);
      while (!s[3] && lat < 20) begin
         chk({tag, " in_ready low while busy"}, s[4], 1'b0);
         tick();
         lat++;
         s = st(w2);
      end
      if (!s[3]) chk({tag, " out_valid timeout"}, 0, 1);
   endtask

   task automatic run_op(input bit w2, input logic [7:0] av, input logic [7:0] bv,
                         input int hold, input logic [2:0] ef, input int elat, input string tag);
      logic [4:0] s;
      int lat;
      s = st(w2);
      chk({tag, " in_ready idle"}, s[4], 1'b1);
      chk({tag, " flags zero idle"}, s[3:0], 4'b0000);
      drive_in(w2, 1'b1, av, bv);
      tick();
      // Garbage on a/b mid-operation must be ignored.
      drive_in(w2, 1'b0, ~av, av ^ 8'h5A);
      wait_ov(w2, tag, lat);
      s = st(w2);
      chk({tag, " latency"}, lat, elat);
      chk({tag, " flags"}, s[2:0], ef);
      chk({tag, " onehot"}, $countones(s[2:0]), 1);
      chk({tag, " in_ready low in done"}, s[4], 1'b0);
      for (int i = 0; i < hold; i++) begin
         tick();
         s = st(w2);
         chk({tag, " held under backpressure"}, s[3:0], {1'b1, ef});
      end
      drive_rdy(w2, 1'b1);
      tick();
      drive_rdy(w2, 1'b0);
      s = st(w2);
      chk({tag, " after handshake"}, s, 5'b10000);
   endtask

   vec_t vecs[8];

   initial begin
      int lat;
      logic [4:0] s;
      logic [7:0] ra, rb;

      vecs[0] = '{8'hA5, 8'hA5, 0, 3'b001, 4};
      vecs[1] = '{8'h80, 8'h40, 0, 3'b100, 1};
      vecs[2] = '{8'hA4, 8'hA6, 0, 3'b010, 4};
      vecs[3] = '{8'h3C, 8'h3B, 3, 3'b100, 3};
      vecs[4] = '{8'h00, 8'h00, 1, 3'b001, 4};
      vecs[5] = '{8'hFF, 8'h00, 0, 3'b100, 1};
      vecs[6] = '{8'h10, 8'h20, 2, 3'b010, 2};
      vecs[7] = '{8'h01, 8'h00, 0, 3'b100, 4};

      // Reset state
      #2;
      chk("reset out_valid8", out_valid8, 1'b0);
      chk("reset flags8", {gt8, lt8, eq8}, 3'b000);
      chk("reset out_valid2", out_valid2, 1'b0);
      chk("reset flags2", {gt2, lt2, eq2}, 3'b000);
      tick();
      rst_n = 1'b1;
      tick();
      chk("in_ready8 after reset", in_ready8, 1'b1);
      chk("in_ready2 after reset", in_ready2, 1'b1);

      // Directed table
      foreach (vecs[i])
         run_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].flags, vecs[i].lat,
                $sformatf("vec%0d", i));

      // WIDTH=2 directed corners
      run_op(1'b1, 8'h02, 8'h01, 0, 3'b100, 1, "w2 gt");
      run_op(1'b1, 8'h00, 8'h03, 1, 3'b010, 1, "w2 lt");
      run_op(1'b1, 8'h03, 8'h03, 0, 3'b001, 1, "w2 eq");

      // Reset in the 2nd COMPARE cycle
      drive_in(1'b0, 1'b1, 8'h55, 8'h56);
      tick();
      drive_in(1'b0, 1'b0, 8'h00, 8'h00);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midreset outputs", st(1'b0), 5'b10000);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("midreset no out_valid", out_valid8, 1'b0);
      end
      run_op(1'b0, 8'h01, 8'h00, 0, 3'b100, 4, "post reset");

      // Result accepted while in_valid high must not start a new op
      drive_in(1'b0, 1'b1, 8'h12, 8'h34);
      tick();
      drive_in(1'b0, 1'b0, 8'h00, 8'h00);
      wait_ov(1'b0, "thru", lat);
      chk("thru lat", lat, 2);
      chk("thru flags", {gt8, lt8, eq8}, 3'b010);
      drive_in(1'b0, 1'b1, 8'hF0, 8'h0F);
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      chk("thru no start on handshake", st(1'b0), 5'b10000);
      tick();
      drive_in(1'b0, 1'b0, 8'h00, 8'h00);
      chk("thru accepted next", in_ready8, 1'b0);
      wait_ov(1'b0, "thru2", lat);
      chk("thru2 lat", lat, 1);
      chk("thru2 flags", {gt8, lt8, eq8}, 3'b100);
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;

      // Random
      for (int i = 0; i < 500; i++) begin
         bit w2;
         int w;
         w2 = (i % 2) == 1;
         w  = w2 ? 2 : 8;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) rb = ra;
         if (w2) begin ra = ra & 8'h03; rb = rb & 8'h03; end
         repeat ($urandom_range(0, 2)) tick();
         run_op(w2, ra, rb, $urandom_range(0, 2), ref_flags(ra, rb), ref_lat(ra, rb, w),
                $sformatf("rnd%0d a=%0h b=%0h", i, ra, rb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
